// File: rtl/acsp_pkg.sv
// Shared definitions for the acquisition-side transmit path.
//   tx_arb_state_t : arbiter FSM states
//   OWN_*          : encodings of the tx_arbiter owner output
//   BYTE_WIDTH     : default width of every byte path
package acsp_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE
  } tx_arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_META = 2'b01;
  localparam logic [1:0] OWN_SAMP = 2'b10;

endpackage

// File: rtl/tx_start_timer.sv
// Loadable down-counter with zero flag, used to bound the wait between the
// UART start pulse and the rise of tx_busy.
//   clock, reset_n : system clock, asynchronous active-low reset
//   load, load_val : load the counter (has priority over dec)
//   dec            : decrement by one; saturates at zero
//   zero           : counter is zero
module tx_start_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates two byte requesters (metadata, sample readout) onto one UART.
// Metadata has fixed priority at grant time; once granted, a requester keeps
// the UART for its whole burst (until last, abort or start timeout).
//   clock, reset_n               : system clock, asynchronous active-low reset
//   meta_req/byte/last, meta_ack : metadata requester handshake
//   samp_req/byte/last, samp_ack : sample-readout requester handshake
//   abort                        : release the grant after the byte in flight
//   tx_busy                      : UART busy
//   trans_en, data_out           : UART start pulse and registered byte
//   owner                        : 00 none, 01 meta, 10 sample
//   byte_count                   : bytes completed in the current burst
//   timeout_err                  : pulse when tx_busy failed to rise in time
module tx_arbiter
  import acsp_pkg::*;
#(
  parameter int BYTE_WIDTH    = acsp_pkg::BYTE_WIDTH,
  parameter int START_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  meta_req,
  input  logic [BYTE_WIDTH-1:0] meta_byte,
  input  logic                  meta_last,
  output logic                  meta_ack,
  input  logic                  samp_req,
  input  logic [BYTE_WIDTH-1:0] samp_byte,
  input  logic                  samp_last,
  output logic                  samp_ack,
  input  logic                  abort,
  input  logic                  tx_busy,
  output logic                  trans_en,
  output logic [BYTE_WIDTH-1:0] data_out,
  output logic [1:0]            owner,
  output logic [15:0]           byte_count,
  output logic                  timeout_err
);

  localparam int TW = $clog2(START_TIMEOUT + 2);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(START_TIMEOUT);

  tx_arb_state_t state;
  logic hold_q;       // byte done, waiting in WAIT_DONE for owner req to return
  logic new_burst_q;  // current ACCEPT is the first of a burst
  logic last_q;
  logic abort_q;

  logic                  own_req;
  logic [BYTE_WIDTH-1:0] own_byte;
  logic                  own_last;
  logic                  abort_seen;
  logic                  timer_load;
  logic                  timer_dec;
  logic                  timer_zero;

  always_comb begin
    own_req  = 1'b0;
    own_byte = '0;
    own_last = 1'b0;
    case (owner)
      OWN_META: begin
        own_req  = meta_req;
        own_byte = meta_byte;
        own_last = meta_last;
      end
      OWN_SAMP: begin
        own_req  = samp_req;
        own_byte = samp_byte;
        own_last = samp_last;
      end
      default: ;
    endcase
  end

  assign abort_seen = abort_q | abort;
  assign timer_load = (state == ST_LAUNCH);
  assign timer_dec  = (state == ST_WAIT_START) && !tx_busy;

  tx_start_timer #(.WIDTH(TW)) u_start_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (TIMEOUT_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Release paths assign owner/state/flags later in the block than the sticky
  // abort capture, so the release always wins on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      owner       <= OWN_NONE;
      meta_ack    <= 1'b0;
      samp_ack    <= 1'b0;
      trans_en    <= 1'b0;
      timeout_err <= 1'b0;
      data_out    <= '0;
      byte_count  <= '0;
      hold_q      <= 1'b0;
      new_burst_q <= 1'b0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      meta_ack    <= 1'b0;
      samp_ack    <= 1'b0;
      trans_en    <= 1'b0;
      timeout_err <= 1'b0;
      if ((state != ST_IDLE) && abort) abort_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          hold_q  <= 1'b0;
          if (meta_req) begin
            owner       <= OWN_META;
            new_burst_q <= 1'b1;
            state       <= ST_ACCEPT;
          end else if (samp_req) begin
            owner       <= OWN_SAMP;
            new_burst_q <= 1'b1;
            state       <= ST_ACCEPT;
          end else begin
            owner <= OWN_NONE;
          end
        end

        ST_ACCEPT: begin
          if (own_req) begin
            data_out    <= own_byte;
            last_q      <= own_last;
            meta_ack    <= (owner == OWN_META);
            samp_ack    <= (owner == OWN_SAMP);
            if (new_burst_q) byte_count <= '0;
            new_burst_q <= 1'b0;
            state       <= ST_LAUNCH;
          end else if (new_burst_q || abort_seen) begin
            // Requester withdrew before its ack: undo the grant.
            owner       <= OWN_NONE;
            new_burst_q <= 1'b0;
            abort_q     <= 1'b0;
            last_q      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            hold_q <= 1'b1;
            state  <= ST_WAIT_DONE;
          end
        end

        ST_LAUNCH: begin
          trans_en <= 1'b1;
          state    <= ST_WAIT_START;
        end

        ST_WAIT_START: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (timer_zero) begin
            timeout_err <= 1'b1;
            owner       <= OWN_NONE;
            abort_q     <= 1'b0;
            last_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        ST_WAIT_DONE: begin
          if (hold_q) begin
            if (abort_seen) begin
              owner   <= OWN_NONE;
              abort_q <= 1'b0;
              hold_q  <= 1'b0;
              last_q  <= 1'b0;
              state   <= ST_IDLE;
            end else if (own_req) begin
              hold_q <= 1'b0;
              state  <= ST_ACCEPT;
            end
          end else if (!tx_busy) begin
            byte_count <= byte_count + 16'd1;
            if (last_q || abort_seen) begin
              owner   <= OWN_NONE;
              abort_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= ST_IDLE;
            end else if (own_req) begin
              state <= ST_ACCEPT;
            end else begin
              hold_q <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
